// File: rtl/run_controller.sv
// rtl/run_controller.sv - button-driven run/pause/halt controller with instruction clock divider and statistics
module run_controller #(
  parameter int DIV_SLOW = 16,
  parameter int DIV_FAST = 4,
  parameter int DEBOUNCE = 8
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        stop_button,
  input  logic        Fre_Choice,
  input  logic        halt,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic        branch_taken,
  output logic        cpu_en,
  output logic        running,
  output logic        halted,
  output logic [15:0] instr_num,
  output logic [15:0] nocondition_num,
  output logic [15:0] condition_num,
  output logic [15:0] condition_success_num
);

  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int DW      = $clog2(DIV_MAX) + 1;
  localparam int BW      = $clog2(DEBOUNCE) + 1;

  localparam logic [DW-1:0] SLOW_LAST = DW'(DIV_SLOW - 1);
  localparam logic [DW-1:0] FAST_LAST = DW'(DIV_FAST - 1);
  localparam logic [BW-1:0] DEB_LAST  = BW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_PAUSE  = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_btn_s1, r_btn_s2;
  logic            r_fre_s1, r_fre_s2;
  logic            r_db_level;
  logic [BW-1:0]   r_db_cnt;
  logic [DW-1:0]   r_div;
  logic [DW-1:0]   w_div_nxt;
  logic            r_cpu_en;
  logic [15:0]     r_instr, r_nocond, r_cond, r_succ;
  logic            w_press;
  logic            w_fre_chg;
  logic [DW-1:0]   w_div_last;
  logic [DW-1:0]   w_div_last_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Press fires on the very edge the debounced level rises, so the FSM reacts with no extra delay.
  assign w_press        = r_btn_s2 & ~r_db_level & (r_db_cnt == DEB_LAST);
  // Synchronized speed select is about to change: the divider restarts from zero on this edge.
  assign w_fre_chg      = r_fre_s1 ^ r_fre_s2;
  assign w_div_last     = r_fre_s2 ? FAST_LAST : SLOW_LAST;
  // Period in force after this edge, used to predict the registered pulse.
  assign w_div_last_nxt = r_fre_s1 ? FAST_LAST : SLOW_LAST;

  // Two-flop synchronizers for the asynchronous button and speed switch.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_fre_s1 <= 1'b0;
      r_fre_s2 <= 1'b0;
    end else begin
      r_btn_s1 <= stop_button;
      r_btn_s2 <= r_btn_s1;
      r_fre_s1 <= Fre_Choice;
      r_fre_s2 <= r_fre_s1;
    end
  end

  // Debouncer: accept a new level only after it has differed for DEBOUNCE consecutive cycles.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
    end else if (r_btn_s2 == r_db_level) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DEB_LAST) begin
      r_db_level <= r_btn_s2;
      r_db_cnt   <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) r_state <= S_PAUSE;
    else      r_state <= w_state_nxt;
  end

  // Next state: halt outranks a simultaneous press; HALTED is only left through reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_PAUSE:  if (w_press) w_state_nxt = S_RUN;
      S_RUN: begin
        if (r_cpu_en && halt) w_state_nxt = S_HALTED;
        else if (w_press)     w_state_nxt = S_PAUSE;
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_PAUSE;
    endcase
  end

  // Divider next value: parked at zero outside RUN and on a speed change, otherwise wraps at the period.
  always_comb begin
    w_div_nxt = r_div;
    if (r_state != S_RUN || w_fre_chg) w_div_nxt = '0;
    else if (r_div >= w_div_last)      w_div_nxt = '0;
    else                               w_div_nxt = r_div + 1'b1;
  end

  // Divider and registered cpu_en pulse, which tracks RUN with the divider at its last count.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_div    <= '0;
      r_cpu_en <= 1'b0;
    end else begin
      r_div    <= w_div_nxt;
      r_cpu_en <= (w_state_nxt == S_RUN) && (w_div_nxt == w_div_last_nxt);
    end
  end

  // Saturating statistics, updated for every executed instruction including the halting one.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_instr  <= '0;
      r_nocond <= '0;
      r_cond   <= '0;
      r_succ   <= '0;
    end else if (r_cpu_en) begin
      r_instr <= sat_inc(r_instr);
      if (is_jump)                  r_nocond <= sat_inc(r_nocond);
      if (is_branch)                r_cond   <= sat_inc(r_cond);
      if (is_branch & branch_taken) r_succ   <= sat_inc(r_succ);
    end
  end

  assign cpu_en                = r_cpu_en;
  assign running               = (r_state == S_RUN);
  assign halted                = (r_state == S_HALTED);
  assign instr_num             = r_instr;
  assign nocondition_num       = r_nocond;
  assign condition_num         = r_cond;
  assign condition_success_num = r_succ;

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - table-driven self-checking bench for run_controller
module tb_run_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        RST;
  logic        btn, fre, hlt_in, jmp, br, tk;
  logic        cpu_en, running, halted;
  logic [15:0] instr_num, nocond_num, cond_num, succ_num;

  logic        s_btn, s_fre, s_jmp;
  logic        s_cpu_en, s_running, s_halted;
  logic [15:0] s_instr, s_nocond, s_cond, s_succ;

  run_controller dut (
    .clk(clk), .RST(RST), .stop_button(btn), .Fre_Choice(fre), .halt(hlt_in),
    .is_jump(jmp), .is_branch(br), .branch_taken(tk),
    .cpu_en(cpu_en), .running(running), .halted(halted),
    .instr_num(instr_num), .nocondition_num(nocond_num),
    .condition_num(cond_num), .condition_success_num(succ_num)
  );

  run_controller #(.DIV_SLOW(2), .DIV_FAST(1), .DEBOUNCE(2)) sat_dut (
    .clk(clk), .RST(RST), .stop_button(s_btn), .Fre_Choice(s_fre), .halt(1'b0),
    .is_jump(s_jmp), .is_branch(1'b0), .branch_taken(1'b0),
    .cpu_en(s_cpu_en), .running(s_running), .halted(s_halted),
    .instr_num(s_instr), .nocondition_num(s_nocond),
    .condition_num(s_cond), .condition_success_num(s_succ)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic b, f, h, j, br, tk;
    int   cyc;
    logic run, hlt;
    int   pulses, instr, nocond, cond, succ;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(input logic b, input logic f, input logic h, input logic j,
                              input logic bri, input logic t, input int c, input logic r,
                              input logic hd, input int p, input int i, input int n,
                              input int cd, input int s);
    vec_t v;
    v.b = b; v.f = f; v.h = h; v.j = j; v.br = bri; v.tk = t; v.cyc = c;
    v.run = r; v.hlt = hd; v.pulses = p; v.instr = i; v.nocond = n; v.cond = cd; v.succ = s;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input int idx);
    chk("rst_running", idx, int'(running), 0);
    chk("rst_halted", idx, int'(halted), 0);
    chk("rst_cpu_en", idx, int'(cpu_en), 0);
    chk("rst_instr", idx, int'(instr_num), 0);
    chk("rst_nocond", idx, int'(nocond_num), 0);
    chk("rst_cond", idx, int'(cond_num), 0);
    chk("rst_succ", idx, int'(succ_num), 0);
  endtask

  initial begin
    int pulses;
    int cyc;

    //            b  f  h  j br tk cyc run hlt pul instr nc cd sc
    vecs[0]  = mk(0, 0, 0, 0, 0, 0,  5, 0, 0, 0,  0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0,  5, 0, 0, 0,  0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 10, 0, 0, 0,  0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0,  9, 0, 0, 0,  0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 0,  1, 1, 0, 0,  0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 14, 1, 0, 0,  0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0,  2, 1, 0, 1,  1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 32, 1, 0, 2,  3, 0, 0, 0);
    vecs[8]  = mk(0, 1, 0, 0, 0, 0,  4, 1, 0, 0,  3, 0, 0, 0);
    vecs[9]  = mk(0, 1, 0, 0, 0, 0,  1, 1, 0, 1,  3, 0, 0, 0);
    vecs[10] = mk(0, 1, 0, 0, 0, 0, 16, 1, 0, 4,  7, 0, 0, 0);
    vecs[11] = mk(0, 1, 0, 0, 1, 1,  4, 1, 0, 1,  8, 0, 1, 1);
    vecs[12] = mk(0, 1, 0, 0, 1, 0,  4, 1, 0, 1,  9, 0, 2, 1);
    vecs[13] = mk(0, 1, 0, 0, 1, 1,  4, 1, 0, 1, 10, 0, 3, 2);
    vecs[14] = mk(0, 1, 0, 1, 0, 0,  4, 1, 0, 1, 11, 1, 3, 2);
    vecs[15] = mk(0, 1, 0, 0, 0, 1,  4, 1, 0, 1, 12, 1, 3, 2);
    vecs[16] = mk(1, 1, 0, 0, 0, 0,  5, 1, 0, 1, 14, 1, 3, 2);
    vecs[17] = mk(0, 1, 0, 0, 0, 0, 12, 1, 0, 3, 17, 1, 3, 2);
    vecs[18] = mk(1, 1, 0, 0, 0, 0,  9, 1, 0, 2, 19, 1, 3, 2);
    vecs[19] = mk(1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 19, 1, 3, 2);
    vecs[20] = mk(1, 1, 0, 0, 0, 0, 30, 0, 0, 0, 19, 1, 3, 2);
    vecs[21] = mk(0, 1, 0, 0, 0, 0, 20, 0, 0, 0, 19, 1, 3, 2);
    vecs[22] = mk(1, 1, 0, 0, 0, 0, 10, 1, 0, 0, 19, 1, 3, 2);
    vecs[23] = mk(0, 1, 0, 0, 0, 0, 14, 1, 0, 3, 22, 1, 3, 2);
    vecs[24] = mk(1, 1, 0, 0, 0, 0,  9, 1, 0, 3, 24, 1, 3, 2);
    vecs[25] = mk(1, 1, 1, 1, 0, 0,  1, 0, 1, 0, 25, 2, 3, 2);
    vecs[26] = mk(0, 1, 1, 1, 0, 0, 20, 0, 1, 0, 25, 2, 3, 2);
    vecs[27] = mk(1, 1, 1, 1, 0, 0, 20, 0, 1, 0, 25, 2, 3, 2);

    RST = 1'b0;
    btn = 1'b0; fre = 1'b0; hlt_in = 1'b0; jmp = 1'b0; br = 1'b0; tk = 1'b0;
    s_btn = 1'b0; s_fre = 1'b1; s_jmp = 1'b1;

    repeat (3) step();
    chk_all_zero(0);
    RST = 1'b1;

    for (int v = 0; v < 28; v++) begin
      btn = vecs[v].b; fre = vecs[v].f; hlt_in = vecs[v].h;
      jmp = vecs[v].j; br = vecs[v].br; tk = vecs[v].tk;
      pulses = 0;
      for (int c = 0; c < vecs[v].cyc; c++) begin
        step();
        if (cpu_en) pulses++;
      end
      chk("running", v, int'(running), int'(vecs[v].run));
      chk("halted", v, int'(halted), int'(vecs[v].hlt));
      chk("pulses", v, pulses, vecs[v].pulses);
      chk("instr_num", v, int'(instr_num), vecs[v].instr);
      chk("nocondition_num", v, int'(nocond_num), vecs[v].nocond);
      chk("condition_num", v, int'(cond_num), vecs[v].cond);
      chk("condition_success_num", v, int'(succ_num), vecs[v].succ);
    end

    // Asynchronous reset from HALTED with nonzero counters, checked before any clock edge.
    @(posedge clk);
    #3;
    RST = 1'b0;
    #1;
    chk_all_zero(1);

    // A press in progress is discarded by reset; a full new press is needed afterwards.
    step();
    btn = 1'b0; hlt_in = 1'b0; jmp = 1'b0;
    RST = 1'b1;
    btn = 1'b1;
    repeat (6) step();
    chk("partial_press_running", 0, int'(running), 0);
    RST = 1'b0;
    step();
    step();
    RST = 1'b1;
    repeat (9) step();
    chk("after_rst_9_running", 0, int'(running), 0);
    step();
    chk("after_rst_10_running", 0, int'(running), 1);
    chk("after_rst_instr", 0, int'(instr_num), 0);
    btn = 1'b0;

    // Saturation on the fast-divider instance: one pulse per cycle once running.
    s_btn = 1'b1;
    pulses = 0;
    cyc = 0;
    while (pulses < 65540 && cyc < 70000) begin
      step();
      cyc++;
      if (s_cpu_en) begin
        pulses++;
        if (pulses == 1000) chk("sat_instr_1000", 0, int'(s_instr), 999);
      end
    end
    chk("sat_pulse_budget", 0, pulses, 65540);
    step();
    chk("sat_instr", 0, int'(s_instr), 65535);
    chk("sat_nocond", 0, int'(s_nocond), 65535);
    chk("sat_cond", 0, int'(s_cond), 0);
    chk("sat_running", 0, int'(s_running), 1);
    chk("sat_halted", 0, int'(s_halted), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
